lut_reverse_search: RTL and testbench

- Programmable key/data lookup table with a sequential reverse search: given a data value, it returns the key of the first valid entry holding that data.
- Serves as the inverse companion to the combinational key->data mux used in NPC decode/control. The same table contents, read in the opposite direction, recover the key (e.g. opcode/funct code) for a given control word.
- Host writes entries through a write port. Searches use valid/ready handshakes on the request and response sides.

---
 rtl/lut_reverse_search_if.sv | 27 ++
 rtl/lut_reverse_search.sv | 134 +++++++++++++
 tb/tb_lut_reverse_search.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_reverse_search_if.sv
// Search request/response bundle for lut_reverse_search.
// master: the requester. It drives req_valid/req_data/resp_ready and receives the response.
// slave:  the table. It drives req_ready and the resp_* fields.
interface lut_reverse_search_if #(
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  parameter int IDX_W    = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [DATA_LEN-1:0] req_data;
  logic                resp_valid;
  logic                resp_ready;
  logic [KEY_LEN-1:0]  resp_key;
  logic [IDX_W-1:0]    resp_idx;
  logic                resp_hit;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_key, resp_idx, resp_hit
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_key, resp_idx, resp_hit
  );
endinterface

// File: rtl/lut_reverse_search.sv
// Programmable key/data table with a sequential reverse (data -> key) search.
// Ports: clk/rst_n; a host write port (wr_en/wr_idx/wr_key/wr_data/clr, wr_ready);
//        default_key for misses; search handshake through the slave side of lut_reverse_search_if.
// Latency: a hit at entry i responds i+1 cycles after accept, a miss after NR_KEY cycles.
// Backpressure: the response is held until it is consumed; no new request or write is taken until then.
module lut_reverse_search #(
  parameter  int NR_KEY      = 4,
  parameter  int KEY_LEN     = 4,
  parameter  int DATA_LEN    = 8,
  parameter  int HAS_DEFAULT = 0,
  localparam int IDX_W       = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  output logic                wr_ready,
  input  logic [KEY_LEN-1:0]  default_key,
  lut_reverse_search_if.slave sif
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t state, state_nxt;

  logic [NR_KEY-1:0]   ent_vld;
  logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
  logic [DATA_LEN-1:0] ent_data [NR_KEY];

  logic [DATA_LEN-1:0] srch_data;
  logic [IDX_W-1:0]    scan_idx;
  logic [KEY_LEN-1:0]  resp_key_q;
  logic [IDX_W-1:0]    resp_idx_q;
  logic                resp_hit_q;

  logic idle;
  logic cur_match;
  logic scan_last;

  assign idle      = (state == IDLE);
  assign cur_match = ent_vld[scan_idx] && (ent_data[scan_idx] == srch_data);
  assign scan_last = (scan_idx == IDX_W'(NR_KEY - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sif.req_valid)           state_nxt = SCAN;
      SCAN:    if (cur_match || scan_last)  state_nxt = RESP;
      RESP:    if (sif.resp_ready)          state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    wr_ready       = idle;
    sif.req_ready  = idle;
    sif.resp_valid = (state == RESP);
    sif.resp_key   = resp_key_q;
    sif.resp_idx   = resp_idx_q;
    sif.resp_hit   = resp_hit_q;
  end

  // Table storage. The host may only touch it while idle, so a scan always sees a stable table.
  // clr wins over a write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        ent_key[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else if (idle) begin
      if (clr) begin
        ent_vld <= '0;
      end else if (wr_en) begin
        // Looping over real entries also drops any out-of-range wr_idx.
        for (int i = 0; i < NR_KEY; i++) begin
          if (32'(wr_idx) == i) begin
            ent_vld[i]  <= 1'b1;
            ent_key[i]  <= wr_key;
            ent_data[i] <= wr_data;
          end
        end
      end
    end
  end

  // Search datapath. The search data is latched at accept, so req_data is free to change afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srch_data  <= '0;
      scan_idx   <= '0;
      resp_key_q <= '0;
      resp_idx_q <= '0;
      resp_hit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sif.req_valid) begin
            srch_data <= sif.req_data;
            scan_idx  <= '0;
          end
        end
        SCAN: begin
          if (cur_match) begin
            resp_key_q <= ent_key[scan_idx];
            resp_idx_q <= scan_idx;
            resp_hit_q <= 1'b1;
          end else if (scan_last) begin
            // On a miss, default_key is taken as it stands in the last scan cycle.
            resp_key_q <= (HAS_DEFAULT != 0) ? default_key : '0;
            resp_idx_q <= '0;
            resp_hit_q <= 1'b0;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_reverse_search.sv
module tb_lut_reverse_search;
  localparam int NR_KEY   = 4;
  localparam int KEY_LEN  = 4;
  localparam int DATA_LEN = 8;
  localparam int IDX_W    = 2;
  localparam logic [3:0] DEF = 4'hF;

  logic clk = 1'b0;
  logic rst_n;
  logic wr_en, clr;
  logic [IDX_W-1:0]    wr_idx;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic [KEY_LEN-1:0]  default_key;
  logic wr_ready0, wr_ready1;
  logic req_valid, resp_ready;
  logic [DATA_LEN-1:0] req_data;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lut_reverse_search_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .IDX_W(IDX_W)) i0 ();
  lut_reverse_search_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .IDX_W(IDX_W)) i1 ();

  assign i0.req_valid  = req_valid;
  assign i0.req_data   = req_data;
  assign i0.resp_ready = resp_ready;
  assign i1.req_valid  = req_valid;
  assign i1.req_data   = req_data;
  assign i1.resp_ready = resp_ready;

  lut_reverse_search #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .wr_ready(wr_ready0), .default_key(default_key), .sif(i0.slave)
  );

  lut_reverse_search #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .wr_ready(wr_ready1), .default_key(default_key), .sif(i1.slave)
  );

  typedef struct {
    logic [3:0] key0;
    logic [3:0] key1;
    logic [1:0] idx;
    logic       hit;
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    bit         do_wr;
    logic [1:0] w_idx;
    logic [3:0] w_key;
    logic [7:0] w_data;
    logic [7:0] s_data;
    logic [3:0] key;
    logic [1:0] idx;
    logic       hit;
    int         delay;
  } vec_t;

  exp_t sb[$];
  vec_t vec[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  task automatic wr(input logic [1:0] ix, input logic [3:0] k, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_idx = ix; wr_key = k; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // One search: push the expectation at accept, pop and compare at the response handshake.
  task automatic search(input logic [7:0] d, input logic [3:0] k, input logic [1:0] ix,
                        input logic h, input int delay, input bit poke);
    exp_t e;
    bit   ok;
    int   first;
    resp_ready = (delay == 0);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_data  = d;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (i0.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      timeout("accept");
      req_valid = 1'b0;
      return;
    end
    e.key0 = h ? k : 4'h0;
    e.key1 = h ? k : DEF;
    e.idx  = h ? ix : 2'd0;
    e.hit  = h;
    e.lat  = h ? int'(ix) + 1 : NR_KEY;
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = ~d;
    if (poke) begin
      wr_en = 1'b1; wr_idx = 2'd2; wr_key = 4'h5; wr_data = 8'h77;
      @(negedge clk);
      chk("wr_ready_in_scan", {31'b0, wr_ready0}, 32'd0);
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    ok = 1'b0;
    for (int n = 0; n < 3 * NR_KEY; n++) begin
      @(negedge clk);
      if (i0.resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      timeout("resp_valid");
      void'(sb.pop_front());
      resp_ready = 1'b1;
      return;
    end
    first = cyc;
    if (delay > 0) begin
      for (int j = 0; j < delay; j++) begin
        if (j > 0) @(negedge clk);
        chk("bp_valid", {31'b0, i0.resp_valid}, 32'd1);
        chk("bp_req_ready", {31'b0, i0.req_ready}, 32'd0);
        chk("bp_key", {28'b0, i0.resp_key}, {28'b0, sb[0].key0});
        chk("bp_idx", {30'b0, i0.resp_idx}, {30'b0, sb[0].idx});
        chk("bp_hit", {31'b0, i0.resp_hit}, {31'b0, sb[0].hit});
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_at_hs", {31'b0, i0.resp_valid}, 32'd1);
    end
    e = sb.pop_front();
    chk("latency", first - e.acc, e.lat);
    chk("key_nodef", {28'b0, i0.resp_key}, {28'b0, e.key0});
    chk("key_def", {28'b0, i1.resp_key}, {28'b0, e.key1});
    chk("idx", {30'b0, i0.resp_idx}, {30'b0, e.idx});
    chk("hit", {31'b0, i0.resp_hit}, {31'b0, e.hit});
    chk("hit_def", {31'b0, i1.resp_hit}, {31'b0, e.hit});
    @(negedge clk);
    chk("valid_after_hs", {31'b0, i0.resp_valid}, 32'd0);
    chk("req_ready_after_hs", {31'b0, i0.req_ready}, 32'd1);
    chk("key_hold", {28'b0, i0.resp_key}, {28'b0, e.key0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; clr = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
    req_valid = 1'b0; req_data = '0; resp_ready = 1'b1; default_key = DEF;

    vec[0] = '{1'b1, 2'd0, 4'h1, 8'h10, 8'h10, 4'h1, 2'd0, 1'b1, 0};
    vec[1] = '{1'b1, 2'd1, 4'h2, 8'h20, 8'h20, 4'h2, 2'd1, 1'b1, 0};
    vec[2] = '{1'b1, 2'd2, 4'h3, 8'h30, 8'h40, 4'h0, 2'd0, 1'b0, 0};
    vec[3] = '{1'b1, 2'd3, 4'h4, 8'h40, 8'h30, 4'h3, 2'd2, 1'b1, 0};
    vec[4] = '{1'b0, 2'd0, 4'h0, 8'h00, 8'h40, 4'h4, 2'd3, 1'b1, 5};
    vec[5] = '{1'b1, 2'd3, 4'h9, 8'h10, 8'h10, 4'h1, 2'd0, 1'b1, 0};
    vec[6] = '{1'b0, 2'd0, 4'h0, 8'h00, 8'h55, 4'h0, 2'd0, 1'b0, 0};
    vec[7] = '{1'b0, 2'd0, 4'h0, 8'h00, 8'h40, 4'h0, 2'd0, 1'b0, 0};
    vec[8] = '{1'b0, 2'd0, 4'h0, 8'h00, 8'h20, 4'h2, 2'd1, 1'b1, 2};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, i0.resp_valid}, 32'd0);
    chk("rst_key", {28'b0, i0.resp_key}, 32'd0);
    chk("rst_key_def", {28'b0, i1.resp_key}, 32'd0);
    chk("rst_idx", {30'b0, i0.resp_idx}, 32'd0);
    chk("rst_hit", {31'b0, i0.resp_hit}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, i0.req_ready}, 32'd1);
    chk("rst_wr_ready", {31'b0, wr_ready0}, 32'd1);

    // Zero data on an empty table must miss
    search(8'h00, 4'h0, 2'd0, 1'b0, 0, 1'b0);

    // Table-driven hits, misses, priority and backpressure
    for (int v = 0; v < 9; v++) begin
      if (vec[v].do_wr) wr(vec[v].w_idx, vec[v].w_key, vec[v].w_data);
      search(vec[v].s_data, vec[v].key, vec[v].idx, vec[v].hit, vec[v].delay, 1'b0);
    end

    // Write attempted during SCAN is dropped
    search(8'h30, 4'h3, 2'd2, 1'b1, 0, 1'b1);
    search(8'h77, 4'h0, 2'd0, 1'b0, 0, 1'b0);

    // clr and wr_en together: clr wins, the write is dropped
    @(posedge clk); #1;
    clr = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_key = 4'h6; wr_data = 8'h88;
    @(posedge clk); #1;
    clr = 1'b0; wr_en = 1'b0;
    search(8'h10, 4'h0, 2'd0, 1'b0, 0, 1'b0);
    search(8'h88, 4'h0, 2'd0, 1'b0, 0, 1'b0);

    // Reset two cycles into a long scan
    wr(2'd3, 4'hA, 8'h66);
    @(posedge clk); #1;
    req_valid = 1'b1; req_data = 8'h66;
    @(negedge clk);
    chk("mid_accept_ready", {31'b0, i0.req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, i0.resp_valid}, 32'd0);
    chk("mid_rst_key_def", {28'b0, i1.resp_key}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < NR_KEY + 2; j++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'b0, i0.resp_valid}, 32'd0);
    end
    chk("post_rst_req_ready", {31'b0, i0.req_ready}, 32'd1);
    search(8'h66, 4'h0, 2'd0, 1'b0, 0, 1'b0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
